// File: rtl/vga_line_fetch.sv
`default_nettype none
// ============================================================================
// Module   : vga_line_fetch
// Brief    : 2x-scaled pixel source fed by ping-pong line buffers prefetched
//            over a req/ack memory port. Macro VGA_LINE_FETCH_TESTPAT_EN swaps
//            the memory path for a coordinate-derived test pattern.
// Revision : 1.0 - initial release
// ============================================================================
module vga_line_fetch #(
  parameter int SRC_W     = 320,
  parameter int SRC_H     = 240,
  parameter int ADDR_W    = 17,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  output logic [11:0]       pixel,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [11:0]       mem_data,
  output logic              underrun
);

  logic w_req_valid;
  assign w_req_valid = (pix_x != 10'h3FF) && (pix_y != 10'h3FF);

`ifdef VGA_LINE_FETCH_TESTPAT_EN

  logic [11:0] r_pixel;
  logic        w_unused;
  assign w_unused = ^{mem_ack, mem_data};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_pixel <= '0;
    else if (w_req_valid)
      r_pixel <= {pix_x[7:4], pix_y[7:4], pix_x[7:4] ^ pix_y[7:4]};
    else
      r_pixel <= '0;
  end

  assign pixel    = r_pixel;
  assign mem_req  = 1'b0;
  assign mem_addr = '0;
  assign underrun = 1'b0;

`else

  localparam int                c_COL_W     = $clog2(SRC_W);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(SRC_W - 1);
  localparam logic [8:0]        c_LINE_LAST = 9'(SRC_H - 1);
  localparam logic [9:0]        c_X_LAST    = 10'(2 * SRC_W - 1);
  localparam logic [9:0]        c_Y_LAST    = 10'(2 * SRC_H - 1);
  localparam logic [ADDR_W-1:0] c_BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_LINE_STEP = ADDR_W'(SRC_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_START = 2'd2
  } state_t;

  state_t              r_state,     w_state_nx;
  logic [c_COL_W-1:0]  r_col,       w_col_nx;
  logic [ADDR_W-1:0]   r_mem_addr,  w_addr_nx;
  logic [ADDR_W-1:0]   r_line_base, w_base_nx;
  logic                r_mem_req,   w_req_nx;
  logic                r_dst,       w_dst_nx;
  logic [1:0]          r_valid,     w_valid_nx;
  logic                r_underrun,  w_underrun_nx;
  logic                r_synced,    w_synced_nx;
  logic [11:0]         r_pixel;
  logic [11:0]         r_lbuf [2][SRC_W];

  logic                w_sel;
  logic [8:0]          w_rcol;
  logic [8:0]          w_src_line;
  logic                w_line_start;
  logic                w_frame_end;
  logic                w_kick;
  logic                w_kick_dst;
  logic [ADDR_W-1:0]   w_kick_base;
  logic                w_wr;

  assign w_sel      = pix_y[1];
  assign w_rcol     = pix_x[9:1];
  assign w_src_line = pix_y[9:1];

  assign w_line_start = w_req_valid && (pix_x == 10'd0) && !pix_y[0];
  assign w_frame_end  = w_req_valid && (pix_x == c_X_LAST) && (pix_y == c_Y_LAST);

  // Line kicks are ignored until a frame-end kick has re-seeded the running
  // line address, so output stays black for the remainder of a partial frame.
  assign w_kick      = w_frame_end ||
                       (w_line_start && r_synced && (w_src_line < c_LINE_LAST));
  assign w_kick_dst  = w_frame_end ? 1'b0 : ~w_src_line[0];
  assign w_kick_base = w_frame_end ? c_BASE : (r_line_base + c_LINE_STEP);

  assign w_wr = (r_state == S_FETCH) && r_mem_req && mem_ack && !w_kick;

  always_comb begin
    w_state_nx    = r_state;
    w_col_nx      = r_col;
    w_addr_nx     = r_mem_addr;
    w_base_nx     = r_line_base;
    w_req_nx      = r_mem_req;
    w_dst_nx      = r_dst;
    w_valid_nx    = r_valid;
    w_underrun_nx = r_underrun;
    w_synced_nx   = r_synced;

    if (w_kick) begin
      w_col_nx               = '0;
      w_addr_nx              = w_kick_base;
      w_base_nx              = w_kick_base;
      w_dst_nx               = w_kick_dst;
      w_valid_nx[w_kick_dst] = 1'b0;
      if (w_frame_end)
        w_synced_nx = 1'b1;
      if (r_state == S_IDLE) begin
        w_state_nx = S_FETCH;
        w_req_nx   = 1'b1;
      end else begin
        // Drop the request for one cycle so the address never moves under
        // an unacknowledged request.
        w_underrun_nx = 1'b1;
        w_state_nx    = S_START;
        w_req_nx      = 1'b0;
      end
    end else begin
      case (r_state)
        S_START: begin
          w_state_nx = S_FETCH;
          w_req_nx   = 1'b1;
        end
        S_FETCH: begin
          if (w_wr) begin
            w_addr_nx = r_mem_addr + 1'b1;
            if (r_col == c_COL_LAST) begin
              w_req_nx          = 1'b0;
              w_valid_nx[r_dst] = 1'b1;
              w_state_nx        = S_IDLE;
            end else begin
              w_col_nx = r_col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_mem_addr  <= '0;
      r_line_base <= '0;
      r_mem_req   <= 1'b0;
      r_dst       <= 1'b0;
      r_valid     <= 2'b00;
      r_underrun  <= 1'b0;
      r_synced    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_col       <= w_col_nx;
      r_mem_addr  <= w_addr_nx;
      r_line_base <= w_base_nx;
      r_mem_req   <= w_req_nx;
      r_dst       <= w_dst_nx;
      r_valid     <= w_valid_nx;
      r_underrun  <= w_underrun_nx;
      r_synced    <= w_synced_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_lbuf[r_dst][r_col] <= mem_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_pixel <= '0;
    else if (w_req_valid && r_valid[w_sel])
      r_pixel <= r_lbuf[w_sel][w_rcol];
    else
      r_pixel <= '0;
  end

  assign pixel    = r_pixel;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign underrun = r_underrun;

`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetch.sv
`default_nettype none
// Directed bench for vga_line_fetch: 320-wide source, 6 source lines per
// frame, with a selectable memory slave (zero-wait, 4-cycle latency, no-ack).
module tb_vga_line_fetch;

  localparam int W  = 320;
  localparam int H  = 6;
  localparam int AW = 17;

  logic          clk   = 1'b0;
  logic          rstn  = 1'b0;
  logic [9:0]    pix_x = 10'h3FF;
  logic [9:0]    pix_y = 10'h3FF;
  logic [11:0]   pixel;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [11:0]   mem_data;
  logic          underrun;

  int n_cmp = 0;
  int n_err = 0;

  // slave mode: 0 zero-wait, 1 four-cycle latency, 2 never acks
  int mode    = 0;
  int lat_cnt = 0;

  int          ack_total = 0;
  int          stab_err  = 0;
  logic        p_req     = 1'b0;
  logic        p_ack     = 1'b0;
  logic [AW-1:0] p_addr  = '0;

  vga_line_fetch #(
    .SRC_W    (W),
    .SRC_H    (H),
    .ADDR_W   (AW),
    .BASE_ADDR(0)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .pix_x   (pix_x),
    .pix_y   (pix_y),
    .pixel   (pixel),
    .mem_req (mem_req),
    .mem_addr(mem_addr),
    .mem_ack (mem_ack),
    .mem_data(mem_data),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  assign mem_data = mem_addr[11:0];

  always_comb begin
    case (mode)
      0:       mem_ack = mem_req;
      1:       mem_ack = mem_req && (lat_cnt == 3);
      default: mem_ack = 1'b0;
    endcase
  end

  always @(posedge clk) lat_cnt <= (mem_req && !mem_ack) ? lat_cnt + 1 : 0;

  always @(negedge clk) begin
    if (mem_req && mem_ack) ack_total <= ack_total + 1;
    if (p_req && !p_ack && mem_req && (mem_addr != p_addr)) stab_err <= stab_err + 1;
    p_req  <= mem_req;
    p_ack  <= mem_ack;
    p_addr <= mem_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [9:0] x, input logic [9:0] y);
    pix_x = x;
    pix_y = y;
    @(posedge clk);
    #1;
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
  endtask

  task automatic apply(input logic [9:0] x, input logic [9:0] y, input int pre,
                       input logic [11:0] exp, input string name);
    idle(pre);
    drive(x, y);
    chk(name, {20'd0, pixel}, {20'd0, exp});
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // One line-start per source line spaced 'gap' idle cycles apart, then frame end.
  task automatic run_frame(input int gap);
    for (int s = 0; s < H; s++) begin
      drive(10'd0, 10'(2 * s));
      idle(gap);
    end
    drive(10'(2 * W - 1), 10'(2 * H - 1));
    idle(gap);
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    int          pre;
    logic [11:0] exp;
  } vec_t;

  vec_t tv [23];

  initial begin
    // frame 1 after reset: unsynced, everything black; frame end kicks line 0
    tv[0]  = '{10'd0,   10'd0,   0,   12'h000};
    tv[1]  = '{10'd2,   10'd0,   0,   12'h000};
    tv[2]  = '{10'd5,   10'd2,   5,   12'h000};
    tv[3]  = '{10'd639, 10'd11,  0,   12'h000};
    // frame 2
    tv[4]  = '{10'd0,   10'd0,   330, 12'h000};
    tv[5]  = '{10'd2,   10'd0,   0,   12'h001};
    tv[6]  = '{10'd638, 10'd1,   0,   12'h13F};
    tv[7]  = '{10'h3FF, 10'h3FF, 0,   12'h000};
    tv[8]  = '{10'd5,   10'd2,   330, 12'h142};
    tv[9]  = '{10'd5,   10'd3,   0,   12'h142};
    tv[10] = '{10'd0,   10'd2,   0,   12'h140};
    tv[11] = '{10'd1,   10'd3,   0,   12'h140};
    tv[12] = '{10'd1,   10'd1,   0,   12'h000};
    tv[13] = '{10'd0,   10'd4,   330, 12'h280};
    tv[14] = '{10'd0,   10'd6,   330, 12'h3C0};
    tv[15] = '{10'd0,   10'd8,   330, 12'h500};
    tv[16] = '{10'd0,   10'd10,  330, 12'h640};
    tv[17] = '{10'd3,   10'd11,  0,   12'h641};
    tv[18] = '{10'd639, 10'd11,  0,   12'h77F};
    tv[19] = '{10'd4,   10'd1,   0,   12'h000};
    tv[20] = '{10'd2,   10'd11,  0,   12'h641};
    // frame 3
    tv[21] = '{10'd0,   10'd0,   330, 12'h000};
    tv[22] = '{10'd639, 10'd0,   0,   12'h13F};

    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_pixel",    {20'd0, pixel}, 32'h0);
    chk("reset_mem_req",  {31'd0, mem_req}, 32'h0);
    chk("reset_mem_addr", {15'd0, mem_addr}, 32'h0);
    chk("reset_underrun", {31'd0, underrun}, 32'h0);
    rstn = 1'b1;

`ifdef VGA_LINE_FETCH_TESTPAT_EN
    apply(10'h035, 10'h02A, 0, 12'h321, "testpat_35_2a");
    apply(10'h3FF, 10'h02A, 0, 12'h000, "testpat_invalid");
    apply(10'd639, 10'd11,  0, 12'h707, "testpat_639_11");
    idle(20);
    chk("testpat_mem_req",  {31'd0, mem_req}, 32'h0);
    chk("testpat_underrun", {31'd0, underrun}, 32'h0);
`else
    mode = 0;
    for (int i = 0; i < 23; i++)
      apply(tv[i].x, tv[i].y, tv[i].pre, tv[i].exp, $sformatf("vec%0d", i));
    idle(330);
    chk("zw_mem_req_idle", {31'd0, mem_req}, 32'h0);
    chk("zw_underrun",     {31'd0, underrun}, 32'h0);

    // slave that never acks: second kick abandons the line-0 fetch
    do_reset();
    mode = 2;
    apply(10'd639, 10'd11, 0, 12'h000, "na_frame_end");
    idle(5);
    chk("na_req_up",      {31'd0, mem_req}, 32'h1);
    chk("na_addr_line0",  {15'd0, mem_addr}, 32'd0);
    chk("na_no_underrun", {31'd0, underrun}, 32'h0);
    apply(10'd0, 10'd0, 0, 12'h000, "na_pixel_black");
    chk("na_underrun_set", {31'd0, underrun}, 32'h1);
    chk("na_addr_restart", {15'd0, mem_addr}, 32'd320);
    idle(3);
    chk("na_req_again",   {31'd0, mem_req}, 32'h1);
    chk("na_addr_hold",   {15'd0, mem_addr}, 32'd320);
    chk("na_pixel_still", {20'd0, pixel}, 32'h0);

    // reset in the middle of a fetch
    mode = 0;
    idle(100);
    chk("mid_fetch_busy", {31'd0, mem_req}, 32'h1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_req",      {31'd0, mem_req}, 32'h0);
    chk("rst_mid_addr",     {15'd0, mem_addr}, 32'h0);
    chk("rst_mid_pixel",    {20'd0, pixel}, 32'h0);
    chk("rst_mid_underrun", {31'd0, underrun}, 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    apply(10'd0, 10'd0, 0, 12'h000, "post_rst_black");
    idle(5);
    chk("post_rst_no_kick", {31'd0, mem_req}, 32'h0);
    apply(10'd639, 10'd11, 0,   12'h000, "post_rst_frame_end");
    apply(10'd0,   10'd0,  330, 12'h000, "post_rst_0_0");
    apply(10'd2,   10'd0,  0,   12'h001, "post_rst_2_0");

    // 4-cycle latency slave over a sync frame plus three full frames
    do_reset();
    mode = 1;
    run_frame(1599);
    for (int f = 0; f < 3; f++) begin
      int a0;
      a0 = ack_total;
      run_frame(1599);
      chk($sformatf("slow_acks_frame%0d", f), ack_total - a0, H * W);
    end
    chk("slow_underrun",   {31'd0, underrun}, 32'h0);
    chk("slow_addr_moved", stab_err, 32'd0);
    apply(10'd6, 10'd0, 0, 12'h003, "slow_pixel_6_0");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
